sobel_stream_ctrl: RTL and testbench

- Streaming sequencer that feeds sobel_core from a raster-ordered grayscale pixel stream.
- Holds two line buffers and a 3x3 window, and tracks row/column position with counters and a small FSM.
- Presents each interior window to an internal sobel_core instance and emits the registered edge magnitude with a valid/ready handshake.
- Sits between the pixel input interface and the output serializer.

---
 rtl/sobel_stream_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sobel_stream_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_ctrl.sv
// Streaming 3x3 Sobel sequencer: two line buffers, a window register and a registered output stage.
// Optional build macro SOBEL_BYPASS_EN adds bypass_i to emit the window centre pixel instead.
module sobel_core #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH-1:0] pix0_0,
  input  logic [PIXEL_WIDTH-1:0] pix0_1,
  input  logic [PIXEL_WIDTH-1:0] pix0_2,
  input  logic [PIXEL_WIDTH-1:0] pix1_0,
  input  logic [PIXEL_WIDTH-1:0] pix1_1,
  input  logic [PIXEL_WIDTH-1:0] pix1_2,
  input  logic [PIXEL_WIDTH-1:0] pix2_0,
  input  logic [PIXEL_WIDTH-1:0] pix2_1,
  input  logic [PIXEL_WIDTH-1:0] pix2_2,
  output logic [PIXEL_WIDTH-1:0] mag
);
  localparam int GW = PIXEL_WIDTH + 4;
  localparam logic [GW-1:0] PIX_MAX = {4'b0000, {PIXEL_WIDTH{1'b1}}};

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0] ax, ay, sum;

  function automatic logic signed [GW-1:0] ext(input logic [PIXEL_WIDTH-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  // |gx| + |gy| with saturation to the pixel range
  always_comb begin
    gx  = (ext(pix0_2) + (ext(pix1_2) <<< 1) + ext(pix2_2))
        - (ext(pix0_0) + (ext(pix1_0) <<< 1) + ext(pix2_0));
    gy  = (ext(pix2_0) + (ext(pix2_1) <<< 1) + ext(pix2_2))
        - (ext(pix0_0) + (ext(pix0_1) <<< 1) + ext(pix0_2));
    ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    sum = ax + ay;
    mag = (sum > PIX_MAX) ? {PIXEL_WIDTH{1'b1}} : sum[PIXEL_WIDTH-1:0];
  end
endmodule

module sobel_stream_ctrl #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [PIXEL_WIDTH-1:0] in_pixel_i,
  input  logic                   in_sof_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [PIXEL_WIDTH-1:0] out_pixel_o,
  output logic                   out_sof_o,
  output logic                   out_eol_o,
  output logic                   frame_done_o,
  output logic                   frame_err_o
`ifdef SOBEL_BYPASS_EN
  ,
  input  logic                   bypass_i
`endif
);
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]             state_q;
  logic [RW-1:0]          row_q, cur_row, nxt_row;
  logic [CW-1:0]          col_q, cur_col, nxt_col;
  logic                   accept, take, restart;
  logic                   run_pos, last_pos, col_wrap, nxt_run;
  logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] win_q [3][3];
  logic [PIXEL_WIDTH-1:0] win_c [3][3];
  logic [PIXEL_WIDTH-1:0] sobel_mag, out_next;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign restart    = accept && in_sof_i;
  // In IDLE only a start-of-frame pixel is stored; anything else is dropped
  assign take       = accept && (in_sof_i || (state_q != IDLE));

  always_comb begin
    cur_row  = in_sof_i ? '0 : row_q;
    cur_col  = in_sof_i ? '0 : col_q;
    run_pos  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    col_wrap = (cur_col == COL_LAST);
    last_pos = (cur_row == ROW_LAST) && col_wrap;
    nxt_col  = col_wrap ? '0 : cur_col + CW'(1);
    nxt_row  = col_wrap ? cur_row + RW'(1) : cur_row;
    nxt_run  = (nxt_row >= RW'(2)) && (nxt_col >= CW'(2));
  end

  // Shifted window columns plus the column formed from the line buffers and the new pixel
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        win_c[r][c] = win_q[r][c+1];
      end
    end
    win_c[0][2] = lb0[cur_col];
    win_c[1][2] = lb1[cur_col];
    win_c[2][2] = in_pixel_i;
  end

  sobel_core #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_core (
    .pix0_0(win_c[0][0]), .pix0_1(win_c[0][1]), .pix0_2(win_c[0][2]),
    .pix1_0(win_c[1][0]), .pix1_1(win_c[1][1]), .pix1_2(win_c[1][2]),
    .pix2_0(win_c[2][0]), .pix2_1(win_c[2][1]), .pix2_2(win_c[2][2]),
    .mag   (sobel_mag)
  );

`ifdef SOBEL_BYPASS_EN
  assign out_next = bypass_i ? win_c[1][1] : sobel_mag;
`else
  assign out_next = sobel_mag;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      frame_done_o <= take && last_pos;
      frame_err_o  <= restart && (state_q != IDLE);
      if (take) begin
        if (last_pos) begin
          state_q <= IDLE;
          row_q   <= '0;
          col_q   <= '0;
        end else begin
          state_q <= nxt_run ? RUN : FILL;
          row_q   <= nxt_row;
          col_q   <= nxt_col;
        end
      end
    end
  end

  // Single output stage; accept is only possible when this register is free or draining
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_pixel_o <= '0;
      out_sof_o   <= 1'b0;
      out_eol_o   <= 1'b0;
    end else if (take && run_pos) begin
      out_valid_o <= 1'b1;
      out_pixel_o <= out_next;
      out_sof_o   <= (cur_row == RW'(2)) && (cur_col == CW'(2));
      out_eol_o   <= col_wrap;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (take) begin
      lb0[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= in_pixel_i;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_c[r][c];
        end
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed scoreboard bench for sobel_stream_ctrl (8x8 frames, 8-bit pixels).
module tb_sobel_stream_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = '0;
  logic       in_sof = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pixel;
  logic       out_sof, out_eol, frame_done, frame_err;
  logic       bypass = 1'b0;
  bit         toggle_mode = 1'b0;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   out_count = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   exp_done = 0;
  int   exp_err = 0;
  int   got[1024];
  int   img[8][8];
  bit   m_idle = 1'b1;
  int   m_row = 0;
  int   m_col = 0;
  int   pat[6] = '{0, 0, 255, 255, 0, 0};

  sobel_stream_ctrl #(.PIXEL_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pixel_i  (in_pixel),
    .in_sof_i    (in_sof),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_pixel_o (out_pixel),
    .out_sof_o   (out_sof),
    .out_eol_o   (out_eol),
    .frame_done_o(frame_done),
    .frame_err_o (frame_err)
`ifdef SOBEL_BYPASS_EN
    ,
    .bypass_i    (bypass)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    out_ready = toggle_mode ? ~out_ready : 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sobelRef(input int r, input int c);
    int gx = 0;
    int gy = 0;
    int m;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        gx += img[r-2+i][c-2+j] * (j - 1) * ((i == 1) ? 2 : 1);
        gy += img[r-2+i][c-2+j] * (i - 1) * ((j == 1) ? 2 : 1);
      end
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int pixVal(input int kind, input int idx);
    int r = idx / 8;
    int c = idx % 8;
    case (kind)
      0:       return 50;
      1:       return (c < 4) ? 0 : 100;
      default: return 8 * r + c;
    endcase
  endfunction

  // Reference controller: updates position and pushes the expected output for one accept
  task automatic modelAccept(input int p, input bit sof);
    exp_t e;
    if (sof) begin
      if (!m_idle) exp_err++;
      m_idle = 1'b0;
      m_row = 0;
      m_col = 0;
    end else if (m_idle) begin
      return;
    end
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      e.pix = bypass ? 8'(img[m_row-1][m_col-1]) : 8'(sobelRef(m_row, m_col));
      e.sof = (m_row == 2 && m_col == 2);
      e.eol = (m_col == 7);
      sb.push_back(e);
    end
    if (m_row == 7 && m_col == 7) begin
      m_idle = 1'b1;
      exp_done++;
      m_row = 0;
      m_col = 0;
    end else if (m_col == 7) begin
      m_col = 0;
      m_row++;
    end else begin
      m_col++;
    end
  endtask

  task automatic sendPixel(input int p, input bit sof);
    int waited = 0;
    in_pixel = 8'(p);
    in_sof   = sof;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      modelAccept(p, sof);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int kind, input int start, input int count, input bit sof_first);
    for (int i = 0; i < count; i++) begin
      sendPixel(pixVal(kind, start + i), sof_first && (i == 0));
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    checkOutput(tag, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  // Output monitor: pops the scoreboard on every completed output handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checkOutput("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_pixel", 32'(out_pixel), 32'(e.pix));
          checkOutput("out_sof", 32'(out_sof), 32'(e.sof));
          checkOutput("out_eol", 32'(out_eol), 32'(e.eol));
        end
        if (out_count < 1024) got[out_count] = int'(out_pixel);
        out_count++;
      end
    end
  end

  initial begin
    int base;
    int errs0;
    int dones0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_pixel", 32'(out_pixel), 32'd0);
    checkOutput("reset_flags", {28'd0, out_sof, out_eol, frame_done, frame_err}, 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #2;

    $display("[TB] flat frame");
    base = out_count;
    dones0 = done_cnt;
    applyStimulus(0, 0, 64, 1'b1);
    waitDrain("flat_drain");
    checkOutput("flat_count", 32'(out_count - base), 32'd36);
    checkOutput("flat_done_pulses", 32'(done_cnt - dones0), 32'd1);
    for (int k = 0; k < 36; k++) checkOutput("flat_value", 32'(got[base+k]), 32'd0);

    $display("[TB] vertical step");
    base = out_count;
    applyStimulus(1, 0, 64, 1'b1);
    waitDrain("step_drain");
    checkOutput("step_count", 32'(out_count - base), 32'd36);
    for (int k = 0; k < 36; k++) checkOutput("step_value", 32'(got[base+k]), 32'(pat[k%6]));

    $display("[TB] vertical step with output backpressure");
    base = out_count;
    toggle_mode = 1'b1;
    applyStimulus(1, 0, 64, 1'b1);
    waitDrain("bp_drain");
    toggle_mode = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("bp_count", 32'(out_count - base), 32'd36);
    for (int k = 0; k < 36; k++) checkOutput("bp_value", 32'(got[base+k]), 32'(pat[k%6]));

    $display("[TB] restart mid-frame");
    base = out_count;
    errs0 = err_cnt;
    applyStimulus(1, 0, 19, 1'b1);
    applyStimulus(1, 0, 64, 1'b1);
    waitDrain("restart_drain");
    checkOutput("restart_err_pulses", 32'(err_cnt - errs0), 32'd1);
    checkOutput("restart_count", 32'(out_count - base), 32'd37);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 0, 30, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    m_idle = 1'b1;
    m_row = 0;
    m_col = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    base = out_count;
    applyStimulus(1, 30, 10, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("dropped_no_outputs", 32'(out_count - base), 32'd0);
    applyStimulus(2, 0, 64, 1'b1);
    waitDrain("post_reset_drain");
    checkOutput("post_reset_count", 32'(out_count - base), 32'd36);

`ifdef SOBEL_BYPASS_EN
    $display("[TB] bypass ramp");
    base = out_count;
    bypass = 1'b1;
    applyStimulus(2, 0, 64, 1'b1);
    waitDrain("bypass_drain");
    bypass = 1'b0;
    for (int k = 0; k < 36; k++)
      checkOutput("bypass_value", 32'(got[base+k]), 32'(8 * (k / 6 + 1) + (k % 6 + 1)));
`endif

    repeat (3) @(posedge clk);
    #2;
    checkOutput("total_done_pulses", 32'(done_cnt), 32'(exp_done));
    checkOutput("total_err_pulses", 32'(err_cnt), 32'(exp_err));
    checkOutput("final_out_valid", 32'(out_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=%0d expected=%0d", out_count, 0);
    $fatal(1, "[TB] global timeout");
  end
endmodule
